// File: rtl/lc3_mem_ctrl_if.sv
// lc3_mem_ctrl_if: memory-side bus between lc3_mem_ctrl (master) and lc3_ram (slave)
interface lc3_mem_ctrl_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16
);
   logic                  mem_cs;
   logic                  mem_r_w;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_data_in;
   logic [DATA_WIDTH-1:0] mem_data_out;
   logic                  mem_ready;
   modport master (output mem_cs, mem_r_w, mem_addr, mem_data_in, input mem_data_out, mem_ready);
   modport slave (input mem_cs, mem_r_w, mem_addr, mem_data_in, output mem_data_out, mem_ready);
endinterface

// File: rtl/lc3_mem_ctrl.sv
// lc3_mem_ctrl: LC-3 MAR/MDR access initiator with timeout; user-mode ACV checking under LC3_ACV_EN
module lc3_mem_ctrl #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16,
   parameter int TIMEOUT    = 15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] mar_in,
   input  logic [DATA_WIDTH-1:0] mdr_in,
   input  logic                  user_mode,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] mdr_out,
   output logic                  err_timeout,
   output logic                  acv,
   lc3_mem_ctrl_if.master        bus
);
`ifdef LC3_ACV_EN
   localparam bit ACV_ON = 1'b1;
`else
   localparam bit ACV_ON = 1'b0;
`endif
   localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);
   typedef enum logic [1:0] {RESYNC, IDLE, ACCESS, RELEASE} state_t;
   state_t                state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  busy_q, busy_d, done_q, done_d, err_q, err_d, acv_q, acv_d;
   logic                  cs_q, cs_d, rw_q, rw_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d, mdr_q, mdr_d;
   logic                  viol;
   assign viol = ACV_ON && user_mode &&
                 (mar_in < ADDR_WIDTH'(16'h3000) || mar_in >= ADDR_WIDTH'(16'hFE00));
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = err_q;
      acv_d   = acv_q;
      cs_d    = cs_q;
      rw_d    = rw_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      mdr_d   = mdr_q;
      case (state_q)
         RESYNC: begin
            busy_d  = bus.mem_ready;
            state_d = bus.mem_ready ? RESYNC : IDLE;
         end
         IDLE: if (req) begin
            err_d   = 1'b0;
            acv_d   = viol;
            done_d  = viol;
            busy_d  = 1'b1;
            cnt_d   = '0;
            state_d = viol ? RELEASE : ACCESS;
            cs_d    = !viol;
            rw_d    = !viol && we;
            addr_d  = viol ? addr_q : mar_in;
            wdata_d = viol ? wdata_q : mdr_in;
         end
         ACCESS: begin
            // ready arriving on the expiry cycle still counts as success
            if (bus.mem_ready || cnt_q == CNT_MAX) begin
               mdr_d   = (bus.mem_ready && !rw_q) ? bus.mem_data_out : mdr_q;
               err_d   = !bus.mem_ready;
               cs_d    = 1'b0;
               rw_d    = 1'b0;
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = RELEASE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RELEASE: begin
            if (!bus.mem_ready) begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end else if (cnt_q == CNT_MAX) begin
               err_d   = 1'b1;
               state_d = RESYNC;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = RESYNC;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RESYNC;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         acv_q   <= 1'b0;
         cs_q    <= 1'b0;
         rw_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         mdr_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         acv_q   <= acv_d;
         cs_q    <= cs_d;
         rw_q    <= rw_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         mdr_q   <= mdr_d;
      end
   end
   assign busy            = busy_q;
   assign done            = done_q;
   assign err_timeout     = err_q;
   assign acv             = acv_q;
   assign mdr_out         = mdr_q;
   assign bus.mem_cs      = cs_q;
   assign bus.mem_r_w     = rw_q;
   assign bus.mem_addr    = addr_q;
   assign bus.mem_data_in = wdata_q;
endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// tb_lc3_mem_ctrl: randomized scoreboard bench for lc3_mem_ctrl against a behavioural RAM and reference memory
module tb_lc3_mem_ctrl;
`ifdef LC3_ACV_EN
   localparam bit ACV_ON = 1'b1;
`else
   localparam bit ACV_ON = 1'b0;
`endif
   localparam int TO = 4;
   typedef struct {
      logic [15:0] mdr;
      logic        err;
      logic        acv;
      int          cs_cyc;
      int          rw_cyc;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [15:0] mar_in = '0;
   logic [15:0] mdr_in = '0;
   logic        user_mode = 1'b0;
   logic        busy, done, err_timeout, acv;
   logic [15:0] mdr_out;
   logic        stall = 1'b0;
   logic [15:0] ram [0:65535];
   logic [15:0] ref_mem [int];
   logic [15:0] last_mdr = '0;
   exp_t        exp_q[$];
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   int          cs_n = 0;
   int          rw_n = 0;
   lc3_mem_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus ();
   lc3_mem_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .mar_in(mar_in), .mdr_in(mdr_in),
      .user_mode(user_mode), .busy(busy), .done(done), .mdr_out(mdr_out),
      .err_timeout(err_timeout), .acv(acv), .bus(bus)
   );
   always #5 clk = ~clk;
   // RAM: ready follows cs one edge late; stall holds it low and blocks the access
   always @(posedge clk) begin
      if (bus.mem_cs && !stall) begin
         bus.mem_data_out <= ram[bus.mem_addr];
         if (bus.mem_r_w) ram[bus.mem_addr] <= bus.mem_data_in;
      end
      bus.mem_ready <= bus.mem_cs && !stall;
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   function automatic logic [15:0] ref_rd(input logic [15:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0000;
   endfunction
   always @(negedge clk) begin
      if (!busy) begin
         cs_n = 0;
         rw_n = 0;
      end else begin
         cs_n += int'(bus.mem_cs);
         rw_n += int'(bus.mem_r_w);
      end
      if (done) begin
         if (exp_q.size() == 0) begin
            chk("spurious_done", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("mdr_out", 32'(mdr_out), 32'(mon_e.mdr));
            chk("err_timeout", 32'(err_timeout), 32'(mon_e.err));
            chk("acv", 32'(acv), 32'(mon_e.acv));
            chk("cs_cycles", cs_n, mon_e.cs_cyc);
            chk("rw_cycles", rw_n, mon_e.rw_cyc);
         end
      end
   end
   task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                         input logic u, input logic st, input logic pk);
      exp_t e;
      int   n;
      logic viol;
      viol = ACV_ON && u && (a < 16'h3000 || a >= 16'hFE00);
      if (!viol && !st) begin
         if (w) ref_mem[int'(a)] = d;
         else last_mdr = ref_rd(a);
      end
      e.mdr    = last_mdr;
      e.err    = !viol && st;
      e.acv    = viol;
      e.cs_cyc = viol ? 0 : (st ? TO : 2);
      e.rw_cyc = w ? e.cs_cyc : 0;
      exp_q.push_back(e);
      stall = st;
      @(negedge clk);
      req = 1'b1;
      we = w;
      mar_in = a;
      mdr_in = d;
      user_mode = u;
      @(negedge clk);
      req = 1'b0;
      chk("accept_busy", 32'(busy), 32'd1);
      chk("accept_err_clr", 32'(err_timeout), 32'd0);
      chk("accept_acv", 32'(acv), 32'(viol));
      n = 1;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("done_latency", n, viol ? 1 : (st ? TO + 1 : 3));
      n = 0;
      if (pk) begin
         req = 1'b1;
         mar_in = a ^ 16'h0004;
         @(negedge clk);
         req = 1'b0;
         n = 1;
      end
      while (busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("busy_latency", n, (viol || st) ? 1 : 2);
      stall = 1'b0;
   endtask
   initial begin
      for (int i = 0; i < 65536; i++) ram[i] = 16'h0000;
      ram[16'h3000] = 16'h1234;
      ref_mem[16'h3000] = 16'h1234;
      repeat (3) @(negedge clk);
      chk("rst_outs", {28'd0, busy, done, err_timeout, acv}, 32'd0);
      chk("rst_bus", {30'd0, bus.mem_cs, bus.mem_r_w}, 32'd0);
      chk("rst_mdr", 32'(mdr_out), 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_after_rst", 32'(busy), 32'd0);
      access(1'b0, 16'h3000, 16'h0000, 1'b0, 1'b0, 1'b0);
      access(1'b1, 16'h3001, 16'hBEEF, 1'b0, 1'b0, 1'b0);
      access(1'b0, 16'h3001, 16'h0000, 1'b0, 1'b0, 1'b0);
      access(1'b0, 16'h3002, 16'h0000, 1'b0, 1'b1, 1'b0);
      access(1'b0, 16'h3000, 16'h0000, 1'b0, 1'b0, 1'b0);
      access(1'b1, 16'h3003, 16'hAAAA, 1'b0, 1'b1, 1'b0);
      access(1'b0, 16'h3003, 16'h0000, 1'b0, 1'b0, 1'b0);
      // reset while the RAM is still presenting ready
      @(negedge clk);
      req = 1'b1;
      we = 1'b0;
      mar_in = 16'h3001;
      user_mode = 1'b0;
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      chk("pre_rst_cs_ready", {30'd0, bus.mem_cs, bus.mem_ready}, 32'd3);
      #1 rst_n = 1'b0;
      #1 chk("midrst_outs", {28'd0, busy, done, bus.mem_cs, bus.mem_r_w}, 32'd0);
      chk("midrst_mdr", 32'(mdr_out), 32'd0);
      #1 rst_n = 1'b1;
      last_mdr = 16'h0000;
      @(negedge clk);
      chk("resync_busy", 32'(busy), 32'd1);
      @(negedge clk);
      chk("resync_exit", 32'(busy), 32'd0);
      access(1'b0, 16'h3000, 16'h0000, 1'b0, 1'b0, 1'b0);
      access(1'b0, 16'h3001, 16'h0000, 1'b0, 1'b0, 1'b1);
      access(1'b1, 16'h3005, 16'h5555, 1'b0, 1'b0, 1'b1);
      access(1'b0, 16'hFE04, 16'h0000, 1'b1, 1'b0, 1'b0);
      access(1'b0, 16'hFE04, 16'h0000, 1'b0, 1'b0, 1'b0);
      access(1'b0, 16'h2FFF, 16'h0000, 1'b1, 1'b0, 1'b0);
      access(1'b0, 16'h3000, 16'h0000, 1'b1, 1'b0, 1'b0);
      access(1'b1, 16'hFDFF, 16'h7777, 1'b1, 1'b0, 1'b0);
      access(1'b0, 16'hFDFF, 16'h0000, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         logic [15:0] a;
         a = 16'h3000 + 16'($urandom_range(0, 7));
         case ($urandom_range(0, 7))
            0: a = 16'h2FFF;
            1: a = 16'hFE00;
            default: ;
         endcase
         access(1'($urandom), a, 16'($urandom), 1'($urandom), $urandom_range(0, 5) == 0,
                $urandom_range(0, 3) == 0);
      end
      repeat (3) @(negedge clk);
      chk("queue_empty", exp_q.size(), 32'd0);
      chk("final_idle", {30'd0, busy, bus.mem_cs}, 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/lc3_mem_ctrl.md
Name: lc3_mem_ctrl

Overview:
- CPU-side memory access initiator for the LC-3 core.
- Takes MAR/MDR load/store requests from the control unit and drives the cs / r_w / addr / data_in handshake into lc3_ram.
- Waits for ready, captures read data into MDR, then releases the bus.
- Provides a timeout error and, optionally, LC-3 user-mode access-control-violation (ACV) checking.

Parameters:
- DATA_WIDTH, 16: memory word width.
- ADDR_WIDTH, 16: memory address width.
- TIMEOUT, 15: maximum cycles to wait for a ready edge before aborting. Legal range 1..255.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  1  access request; sampled only in IDLE.
- we  input  1  1 = store, 0 = load; captured with req.
- mar_in  input  ADDR_WIDTH  access address; captured with req.
- mdr_in  input  DATA_WIDTH  store data; captured with req.
- user_mode  input  1  PSR[15]; captured with req; used only with LC3_ACV_EN.
- busy  output  1  high from request acceptance until return to IDLE, and during RESYNC.
- done  output  1  one-cycle pulse when an access completes, succeeds or fails.
- mdr_out  output  DATA_WIDTH  last successfully loaded word.
- err_timeout  output  1  sticky; set on timeout; cleared by the next accepted req.
- acv  output  1  sticky access-control violation; cleared by the next accepted req.
- mem_cs  output  1  chip select to RAM.
- mem_r_w  output  1  RAM write enable (1 = write).
- mem_addr  output  ADDR_WIDTH  RAM address.
- mem_data_in  output  DATA_WIDTH  RAM write data.
- mem_data_out  input  DATA_WIDTH  RAM read data.
- mem_ready  input  1  RAM ready. Registered by the RAM: rises the edge after cs is sampled high, stays high while cs stays high, falls the edge after cs is sampled low.

Behaviour:
- Reset (async, rst_n = 0):
  - all outputs 0; state = RESYNC; wait counter = 0.
- Outputs: all registered.
- States: RESYNC, IDLE, ACCESS, RELEASE.
- RESYNC:
  - busy = 1.
  - If mem_ready == 0, go to IDLE and set busy = 0.
  - Guarantees no request starts while the RAM is still asserting ready after a mid-access reset.
- IDLE, req = 1:
  - Capture we, mar_in, mdr_in, user_mode.
  - Clear err_timeout and acv.
  - Set busy = 1, mem_cs = 1, mem_r_w = we, mem_addr = mar_in, mem_data_in = mdr_in.
  - Go to ACCESS; counter = 0.
  - req asserted while busy is ignored; it is not queued.
- ACCESS:
  - If mem_ready == 1:
    - On a load, mdr_out <= mem_data_out. On a store, mdr_out is unchanged; the RAM returns pre-write data, which is discarded.
    - Set mem_cs = 0, mem_r_w = 0, done = 1 for one cycle.
    - Go to RELEASE; counter = 0.
  - Else, if counter == TIMEOUT-1: mem_cs = 0, err_timeout = 1, done = 1, go to RELEASE.
  - Else: counter increments.
- RELEASE:
  - If mem_ready == 0: busy = 0, go to IDLE.
  - Else, if counter == TIMEOUT-1: err_timeout = 1, go to RESYNC.
  - Else: counter increments.
  - No second done pulse is issued from RELEASE.
- Nominal latency with lc3_ram:
  - req sampled at edge E0; mem_ready high after E1; data captured and done asserted after E2; busy low after E4.
  - Back-to-back throughput: one access per 5 cycles.
- mem_addr and mem_data_in hold their values after an access. Only mem_cs and mem_r_w return to 0.
- Counter width is 8 bits.
- Simultaneous events:
  - Reset dominates everything.
  - In ACCESS, a ready that arrives in the same cycle the counter expires counts as success.

Optional Feature:
- Macro: LC3_ACV_EN.
- When defined, on req in IDLE with user_mode == 1 and (mar_in < 16'h3000 or mar_in >= 16'hFE00):
  - mem_cs stays 0; acv = 1 and done = 1 on the next edge; busy = 0 on the following edge.
  - mdr_out is unchanged; no RAM access occurs.
- When not defined: acv is tied 0, user_mode is ignored, and every request proceeds to ACCESS.

Test Plan:
- Load: RAM[16'h3000] = 16'h1234; req = 1, we = 0, mar_in = 16'h3000 -> mem_cs high 2 cycles, done pulse at cycle 3, mdr_out = 16'h1234, busy low after cycle 5, err_timeout = 0.
- Store then load: we = 1, mar_in = 16'h3001, mdr_in = 16'hBEEF, then load 16'h3001 -> store does not change mdr_out; load yields 16'hBEEF; mem_r_w high only during the store's ACCESS.
- Timeout: RAM model holds mem_ready = 0, TIMEOUT = 4 -> mem_cs drops after 4 cycles, done pulses, err_timeout = 1; next req clears err_timeout.
- Reset mid-access: assert rst_n = 0 while mem_cs = 1 and mem_ready = 1 -> outputs 0 immediately; busy = 1 in RESYNC until mem_ready = 0; then a new load of 16'h3000 returns the correct data.
- Busy rejection: pulse req during RELEASE -> no extra mem_cs assertion and only one done pulse.
- ACV (LC3_ACV_EN defined): user_mode = 1, mar_in = 16'hFE04 -> acv = 1, done = 1, mem_cs never asserted. Same access with user_mode = 0 -> normal load, acv = 0.
